// File: rtl/instr_decode_queue.sv
// instr_decode_queue: DEPTH-entry instruction FIFO with valid/ready on both
// sides. The head entry is presented split into funct, immA and immB fields.
// Optional feature macro: INSTR_DECODE_ILLEGAL_DROP_EN
//   defined   -> illegal instructions are accepted but discarded, err_count
//                counts them, and out_illegal is tied low.
//   undefined -> every instruction is queued and out_illegal flags the head.
module instr_decode_queue #(
  parameter int IMM_W   = 16,
  parameter int FUNCT_W = 3,
  parameter int DEPTH   = 4,
  parameter logic [2**FUNCT_W-1:0] FUNCT_MASK = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [FUNCT_W+2*IMM_W-1:0]   in_instr,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [FUNCT_W-1:0]           out_funct,
  output logic [IMM_W-1:0]             out_immA,
  output logic [IMM_W-1:0]             out_immB,
  output logic                         out_illegal,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
  output logic [7:0]                   err_count,
`endif
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int INSTR_W = FUNCT_W + 2*IMM_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [INSTR_W-1:0] head;
  logic [FUNCT_W-1:0] head_funct;
  logic               push;
  logic               pop;
  logic               store;

  // Handshake flags come only from the registered occupancy, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign head = mem[rd_ptr];
  assign head_funct = head[INSTR_W-1 -: FUNCT_W];

`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
  logic in_legal;
  assign in_legal = FUNCT_MASK[in_instr[INSTR_W-1 -: FUNCT_W]];
  // An illegal instruction still completes its handshake but is not stored.
  assign store = push && in_legal;
`else
  assign store = push;
`endif

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(store) - CNT_W'(pop);
    end
  end

  // Storage write; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (store && !reset && !flush) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // Head decode, forced to zero whenever the queue is empty.
  always_comb begin
    out_funct = '0;
    out_immA  = '0;
    out_immB  = '0;
    if (out_valid) begin
      out_funct = head_funct;
      out_immA  = head[2*IMM_W-1 -: IMM_W];
      out_immB  = head[IMM_W-1:0];
    end
  end

`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
  assign out_illegal = 1'b0;

  // Saturating count of instructions discarded for an illegal funct.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (flush) begin
      err_count <= '0;
    end else if (push && !in_legal && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign out_illegal = out_valid && !FUNCT_MASK[head_funct];
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue (DEPTH=4, FUNCT_MASK=8'h0F).
// A queue-based reference model tracks what the FIFO should hold, and a
// compare process checks every output on every falling clock edge. Directed
// steps additionally check hand-computed literal values.
module tb_instr_decode_queue;

  localparam int IMM_W   = 16;
  localparam int FUNCT_W = 3;
  localparam int DEPTH   = 4;
  localparam int INSTR_W = FUNCT_W + 2*IMM_W;
  localparam logic [7:0] MASK = 8'h0F;

  logic               clk;
  logic               reset;
  logic [INSTR_W-1:0] in_instr;
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] out_funct;
  logic [IMM_W-1:0]   out_immA;
  logic [IMM_W-1:0]   out_immB;
  logic               out_illegal;
  logic               out_valid;
  logic               out_ready;
  logic               flush;
  logic [2:0]         count;
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
  logic [7:0]         err_count;
`endif

  int n_compared = 0;
  int n_mismatched = 0;
  bit check_en = 0;

  instr_decode_queue #(
    .IMM_W(IMM_W), .FUNCT_W(FUNCT_W), .DEPTH(DEPTH), .FUNCT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_funct(out_funct), .out_immA(out_immA),
    .out_immB(out_immB), .out_illegal(out_illegal), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush),
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
    .err_count(err_count),
`endif
    .count(count)
  );

  // Free-running 10-unit clock.
  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: an ordinary queue plus an error counter. It only looks
  // at the inputs on each rising edge and applies the push/pop rules.
  logic [INSTR_W-1:0] model_q[$];
  int model_err = 0;
  bit m_push;
  bit m_pop;
  always @(posedge clk) begin
    if (reset || flush) begin
      model_q.delete();
      model_err = 0;
    end else begin
      m_pop = out_ready && (model_q.size() > 0);
      m_push = in_valid && (model_q.size() < DEPTH);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) begin
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
        if (!MASK[in_instr[INSTR_W-1 -: FUNCT_W]]) begin
          if (model_err < 255) model_err++;
        end else begin
          model_q.push_back(in_instr);
        end
`else
        model_q.push_back(in_instr);
`endif
      end
    end
  end

  // Per-cycle comparison of every output against the model, on the falling
  // edge so the registered state has settled.
  logic [INSTR_W-1:0] m_head;
  logic               m_ill;
  logic [40:0]        m_exp;
  logic [40:0]        m_act;
  always @(negedge clk) begin
    if (check_en) begin
      m_head = (model_q.size() > 0) ? model_q[0] : '0;
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
      m_ill = 1'b0;
`else
      m_ill = (model_q.size() > 0) && !MASK[m_head[INSTR_W-1 -: FUNCT_W]];
`endif
      m_exp = {3'(model_q.size()), model_q.size() > 0, model_q.size() < DEPTH, m_head, m_ill};
      m_act = {count, out_valid, in_ready, out_funct, out_immA, out_immB, out_illegal};
      n_compared++;
      if (m_act !== m_exp) begin
        n_mismatched++;
        $display("[TB] FAIL model_cycle t=%0t actual=%h required=%h", $time, m_act, m_exp);
      end
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
      n_compared++;
      if (err_count !== 8'(model_err)) begin
        n_mismatched++;
        $display("[TB] FAIL model_err_count t=%0t actual=%0d required=%0d", $time, err_count, model_err);
      end
`endif
    end
  end

  function automatic logic [INSTR_W-1:0] mk(logic [2:0] f, logic [15:0] a, logic [15:0] b);
    return {f, a, b};
  endfunction

  // Drive one cycle of inputs, then wait just past the rising edge.
  task automatic applyStimulus(input logic iv, input logic [INSTR_W-1:0] instr,
                               input logic ordy, input logic fl, input logic rst);
    in_valid = iv;
    in_instr = instr;
    out_ready = ordy;
    flush = fl;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  // Compare the outputs with a hand-computed expectation.
  task automatic checkOutput(input string name, input int exp_count, input logic exp_valid,
                             input logic exp_in_ready, input logic [INSTR_W-1:0] exp_instr,
                             input logic exp_ill);
    logic [40:0] exp_v;
    logic [40:0] act_v;
    exp_v = {3'(exp_count), exp_valid, exp_in_ready, exp_instr, exp_ill};
    act_v = {count, out_valid, in_ready, out_funct, out_immA, out_immB, out_illegal};
    n_compared++;
    if (act_v !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act_v, exp_v);
    end
  endtask

  logic [INSTR_W-1:0] fill [4];
  logic [INSTR_W-1:0] seq [12];
  logic [INSTR_W-1:0] bad;

  // Directed scenario sequence.
  initial begin
    in_valid = 0; in_instr = '0; out_ready = 0; flush = 0; reset = 1;
    applyStimulus(0, '0, 0, 0, 1);
    check_en = 1;
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("reset_state", 0, 0, 1, '0, 0);

    // Single push then pop.
    applyStimulus(1, 35'h2_0003_0005, 0, 0, 0);
    checkOutput("single_push", 1, 1, 1, 35'h2_0003_0005, 0);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("single_pop", 0, 0, 1, '0, 0);

    // Fill to full, reject a fifth offer, drain in order.
    fill[0] = mk(3'd1, 16'h1111, 16'hAAAA);
    fill[1] = mk(3'd3, 16'h2222, 16'hBBBB);
    fill[2] = mk(3'd0, 16'h3333, 16'hCCCC);
    fill[3] = mk(3'd2, 16'h4444, 16'hDDDD);
    for (int i = 0; i < 4; i++) applyStimulus(1, fill[i], 0, 0, 0);
    checkOutput("full", 4, 1, 0, fill[0], 0);
    applyStimulus(1, mk(3'd3, 16'h5555, 16'hEEEE), 0, 0, 0);
    checkOutput("full_reject", 4, 1, 0, fill[0], 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 0, 0);
      checkOutput("drain_order", 3 - i, i < 3, 1, (i < 3) ? fill[i+1] : '0, 0);
    end

    // Ten cycles of simultaneous push/pop at occupancy 2; pointers wrap.
    for (int k = 0; k < 12; k++) seq[k] = mk(3'(k % 4), 16'h0100 + 16'(k), 16'hA000 + 16'(k));
    applyStimulus(1, seq[0], 0, 0, 0);
    applyStimulus(1, seq[1], 0, 0, 0);
    checkOutput("pair_loaded", 2, 1, 1, seq[0], 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, seq[k+2], 1, 0, 0);
      checkOutput("push_pop_steady", 2, 1, 1, seq[k+1], 0);
    end
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("pair_drain1", 1, 1, 1, seq[11], 0);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("pair_drain2", 0, 0, 1, '0, 0);

    // Flush at occupancy 3 with a concurrent push and pop.
    for (int i = 0; i < 3; i++) applyStimulus(1, fill[i], 0, 0, 0);
    checkOutput("pre_flush", 3, 1, 1, fill[0], 0);
    applyStimulus(1, mk(3'd1, 16'hF00D, 16'hBEEF), 1, 1, 0);
    checkOutput("flush", 0, 0, 1, '0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("flush_nostore", 0, 0, 1, '0, 0);

    // Illegal funct 5 with mask 8'h0F.
    bad = mk(3'd5, 16'h1234, 16'h5678);
    applyStimulus(1, bad, 0, 0, 0);
`ifdef INSTR_DECODE_ILLEGAL_DROP_EN
    checkOutput("illegal_dropped", 0, 0, 1, '0, 0);
    n_compared++;
    if (err_count !== 8'd1) begin
      n_mismatched++;
      $display("[TB] FAIL err_count_one actual=%0d required=1", err_count);
    end
    applyStimulus(0, '0, 0, 1, 0);
    n_compared++;
    if (err_count !== 8'd0) begin
      n_mismatched++;
      $display("[TB] FAIL err_count_flush actual=%0d required=0", err_count);
    end
`else
    checkOutput("illegal_queued", 1, 1, 1, bad, 1);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("illegal_popped", 0, 0, 1, '0, 0);
`endif

    // Reset mid-transfer at occupancy 2 with a concurrent offer.
    applyStimulus(1, fill[1], 0, 0, 0);
    applyStimulus(1, fill[3], 0, 0, 0);
    checkOutput("pre_reset", 2, 1, 1, fill[1], 0);
    applyStimulus(1, fill[2], 0, 0, 1);
    checkOutput("reset_mid", 0, 0, 1, '0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("post_reset_idle", 0, 0, 1, '0, 0);

    applyStimulus(0, '0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
